tcp_conn_controller: RTL
========================

TCP_CONN_CONTROLLER -- requirements
Module: tcp_conn_controller

Interface
REQ-001 SHALL have parameter LOCAL_PORT, default 16'd80, the TCP port served.
REQ-002 SHALL have parameter ISS, default 32'h0000_1000, the initial send sequence number.
REQ-003 SHALL have ports: clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: meta_valid in 1, metadata offer from the TCP parser; meta_ready out 1, metadata accept.
REQ-005 SHALL have ports: meta_src_port in 16; meta_dst_port in 16; meta_seq_num in 32; meta_ack_num in 32; meta_flags in 8; meta_window_size in 16; meta_payload_len in 16.
REQ-006 SHALL have ports: payload_commit out 1, one-cycle pulse, keep the buffered payload; payload_drop out 1, one-cycle pulse, discard it.
REQ-007 SHALL have ports: tx_req_valid out 1; tx_req_ready in 1; tx_req_flags out 8; tx_req_seq out 32; tx_req_ack out 32; tx_req_dst_port out 16.
REQ-008 SHALL have ports: conn_state out 2, current state encoding; peer_window out 16, last accepted peer window.

Function
REQ-009 Flag bits SHALL be: FIN=0, SYN=1, RST=2, PSH=3, ACK=4.
REQ-010 SHALL have states: LISTEN=0, SYN_RCVD=1, ESTABLISHED=2, LAST_ACK=3.
REQ-011 meta_ready SHALL be 1 only when there is no evaluation in progress and tx_req_valid=0.
REQ-012 The metadata SHALL be captured on the meta_valid&&meta_ready edge and evaluated in the following cycle.
REQ-013 Evaluation SHALL raise exactly one of payload_commit/payload_drop for one cycle, with the state update and any tx request on the same edge.
REQ-014 payload_commit SHALL fire only for an in-order segment with payload_len>0 in SYN_RCVD (after promotion) or ESTABLISHED; every other evaluation SHALL fire payload_drop.
REQ-015 dst_port != LOCAL_PORT SHALL drop with no state change and no tx request.
REQ-016 RST set with matching ports, in any state other than LISTEN, SHALL clear peer port, rcv_nxt and snd_nxt, go to LISTEN and drop.
REQ-017 In LISTEN, SYN=1 with ACK=0 SHALL:
- record peer_port=src_port;
- set rcv_nxt=seq+1 and snd_nxt=ISS+1;
- request flags SYN|ACK, seq=ISS, ack=rcv_nxt;
- go to SYN_RCVD.
All other segments in LISTEN SHALL drop.
REQ-018 In SYN_RCVD, ACK=1 with src_port==peer_port and ack_num==snd_nxt SHALL go to ESTABLISHED and apply the ESTABLISHED data rule to the same segment; otherwise drop with no change.
REQ-019 In ESTABLISHED, src_port != peer_port SHALL drop silently.
REQ-020 In ESTABLISHED, seq==rcv_nxt SHALL:
- set rcv_nxt += payload_len (+1 if FIN);
- set peer_window=window_size;
- if FIN: request FIN|ACK, seq=snd_nxt, ack=new rcv_nxt, set snd_nxt+=1, go to LAST_ACK;
- else if payload_len>0: request ACK, seq=snd_nxt, ack=new rcv_nxt;
- else: no request.
REQ-021 In ESTABLISHED, seq != rcv_nxt with payload_len>0 or FIN SHALL drop and request a duplicate ACK (seq=snd_nxt, ack=rcv_nxt, unchanged); otherwise drop silently.
REQ-022 In LAST_ACK, ACK=1 with ack_num==snd_nxt SHALL go to LISTEN and clear the connection registers; otherwise drop.
REQ-023 All sequence arithmetic SHALL be modulo 2^32; payload_len SHALL be zero-extended to 32 bits.
REQ-024 tx_req_dst_port SHALL equal peer_port; the tx request fields SHALL stay stable while tx_req_valid=1 and clear on the tx_req_valid&&tx_req_ready edge.

Reset
REQ-025 Reset SHALL be asynchronous and active-low, applied on rst_n falling edge regardless of clk.
REQ-026 During reset all outputs SHALL be 0, state LISTEN, and all internal registers 0; meta_ready SHALL rise the first clock after release.
REQ-027 Reset during a pending tx request or an evaluation SHALL abandon it with no commit/drop pulse.

Structure
REQ-028 Package tcp_ctrl_pkg SHALL hold the conn_state_e enum, the flag bit index constants, and the LOCAL_PORT/ISS defaults.
REQ-029 One sub-module, tcp_tx_req_slot, SHALL implement the single-entry valid/ready request holding register; everything else lives in the top module.

Verification
REQ-030 SYN from port 1234, seq=100, dst=80 -> drop; tx SYN|ACK seq=0x1000 ack=101 dst=1234; conn_state=1.
REQ-031 Then ACK with ack=0x1001, seq=101, len=10 -> commit; state ESTABLISHED; tx ACK seq=0x1001 ack=111.
REQ-032 Out-of-order segment seq=200, len=5 -> drop; duplicate ACK ack=111; rcv_nxt unchanged.
REQ-033 FIN seq=111, len=0 -> drop; tx FIN|ACK seq=0x1001 ack=112; then ACK ack=0x1002 -> LISTEN.
REQ-034 With rcv_nxt=0xFFFF_FFFE, in-order len=4 -> commit, ack=0x0000_0002. Holding tx_req_ready=0 for 5 cycles -> meta_ready stays 0 and the request fields stay stable.
REQ-035 Segment to dst=81 -> drop with no tx. RST mid-connection -> LISTEN. rst_n low while tx_req_valid=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/tcp_ctrl_pkg.sv
// tcp_ctrl_pkg: shared connection-state encoding, TCP flag bit positions and port/ISS defaults
package tcp_ctrl_pkg;
   typedef enum logic [1:0] {
      LISTEN      = 2'd0,
      SYN_RCVD    = 2'd1,
      ESTABLISHED = 2'd2,
      LAST_ACK    = 2'd3
   } conn_state_e;
   localparam int FLAG_FIN = 0;
   localparam int FLAG_SYN = 1;
   localparam int FLAG_RST = 2;
   localparam int FLAG_PSH = 3;
   localparam int FLAG_ACK = 4;
   localparam logic [15:0] DEF_LOCAL_PORT = 16'd80;
   localparam logic [31:0] DEF_ISS = 32'h0000_1000;
endpackage

// File: rtl/tcp_tx_req_slot.sv
// tcp_tx_req_slot: single-entry valid/ready holding register for outgoing segment requests
module tcp_tx_req_slot (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [7:0]  load_flags,
   input  logic [31:0] load_seq,
   input  logic [31:0] load_ack,
   input  logic [15:0] load_dst,
   input  logic        ready,
   output logic        valid,
   output logic [7:0]  flags,
   output logic [31:0] seq,
   output logic [31:0] ack,
   output logic [15:0] dst_port
);
   // hold the request until the consumer takes it, then clear every field
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         flags    <= '0;
         seq      <= '0;
         ack      <= '0;
         dst_port <= '0;
      end else if (load) begin
         valid    <= 1'b1;
         flags    <= load_flags;
         seq      <= load_seq;
         ack      <= load_ack;
         dst_port <= load_dst;
      end else if (valid && ready) begin
         valid    <= 1'b0;
         flags    <= '0;
         seq      <= '0;
         ack      <= '0;
         dst_port <= '0;
      end
   end
endmodule

// File: rtl/tcp_conn_controller.sv
// tcp_conn_controller: single-connection passive TCP state machine driving payload keep/discard and ACK generation
module tcp_conn_controller
   import tcp_ctrl_pkg::*;
#(
   parameter logic [15:0] LOCAL_PORT = DEF_LOCAL_PORT,
   parameter logic [31:0] ISS        = DEF_ISS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        meta_valid,
   output logic        meta_ready,
   input  logic [15:0] meta_src_port,
   input  logic [15:0] meta_dst_port,
   input  logic [31:0] meta_seq_num,
   input  logic [31:0] meta_ack_num,
   input  logic [7:0]  meta_flags,
   input  logic [15:0] meta_window_size,
   input  logic [15:0] meta_payload_len,
   output logic        payload_commit,
   output logic        payload_drop,
   output logic        tx_req_valid,
   input  logic        tx_req_ready,
   output logic [7:0]  tx_req_flags,
   output logic [31:0] tx_req_seq,
   output logic [31:0] tx_req_ack,
   output logic [15:0] tx_req_dst_port,
   output logic [1:0]  conn_state,
   output logic [15:0] peer_window
);
   conn_state_e state, state_nx;
   logic        run, eval;
   logic [15:0] m_src, m_dst, m_win, m_len;
   logic [31:0] m_seq, m_ack;
   logic [7:0]  m_flags;
   logic [15:0] peer_port, peer_nx, win_nx;
   logic [31:0] rcv_nxt, rcv_nx, snd_nxt, snd_nx, new_rcv;
   logic        f_fin, f_syn, f_rst, f_ack;
   logic        port_match, peer_match, promote, data_st, in_order, rst_hit, has_data;
   logic        commit_nx, tx_load;
   logic [7:0]  tx_flags_nx;
   logic [31:0] tx_seq_nx, tx_ack_nx;
   logic        unused_flags;

   assign f_fin        = m_flags[FLAG_FIN];
   assign f_syn        = m_flags[FLAG_SYN];
   assign f_rst        = m_flags[FLAG_RST];
   assign f_ack        = m_flags[FLAG_ACK];
   assign unused_flags = &{1'b0, m_flags[7:5], m_flags[FLAG_PSH]};
   assign port_match   = m_dst == LOCAL_PORT;
   assign peer_match   = m_src == peer_port;
   assign has_data     = |m_len;
   assign in_order     = m_seq == rcv_nxt;
   assign new_rcv      = rcv_nxt + {16'd0, m_len} + {31'd0, f_fin};
   assign rst_hit      = port_match && f_rst && state != LISTEN && peer_match;
   assign promote      = state == SYN_RCVD && f_ack && peer_match && m_ack == snd_nxt;
   assign data_st      = (state == ESTABLISHED && peer_match) || promote;
   assign meta_ready   = run && !eval && !tx_req_valid;
   assign conn_state   = state;

   // state and connection registers; metadata capture; registered commit/drop pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= LISTEN;
         run            <= 1'b0;
         eval           <= 1'b0;
         m_src          <= '0;
         m_dst          <= '0;
         m_seq          <= '0;
         m_ack          <= '0;
         m_flags        <= '0;
         m_win          <= '0;
         m_len          <= '0;
         peer_port      <= '0;
         rcv_nxt        <= '0;
         snd_nxt        <= '0;
         peer_window    <= '0;
         payload_commit <= 1'b0;
         payload_drop   <= 1'b0;
      end else begin
         run            <= 1'b1;
         eval           <= meta_valid && meta_ready;
         state          <= state_nx;
         peer_port      <= peer_nx;
         rcv_nxt        <= rcv_nx;
         snd_nxt        <= snd_nx;
         peer_window    <= win_nx;
         payload_commit <= eval && commit_nx;
         payload_drop   <= eval && !commit_nx;
         if (meta_valid && meta_ready) begin
            m_src   <= meta_src_port;
            m_dst   <= meta_dst_port;
            m_seq   <= meta_seq_num;
            m_ack   <= meta_ack_num;
            m_flags <= meta_flags;
            m_win   <= meta_window_size;
            m_len   <= meta_payload_len;
         end
      end
   end

   // next state and connection register updates for the segment under evaluation
   always_comb begin
      state_nx = state;
      peer_nx  = peer_port;
      rcv_nx   = rcv_nxt;
      snd_nx   = snd_nxt;
      win_nx   = peer_window;
      if (eval && port_match) begin
         if (rst_hit) begin
            state_nx = LISTEN;
            peer_nx  = '0;
            rcv_nx   = '0;
            snd_nx   = '0;
         end else if (state == LISTEN) begin
            if (f_syn && !f_ack) begin
               state_nx = SYN_RCVD;
               peer_nx  = m_src;
               rcv_nx   = m_seq + 32'd1;
               snd_nx   = ISS + 32'd1;
            end
         end else if (state == LAST_ACK) begin
            if (f_ack && m_ack == snd_nxt) begin
               state_nx = LISTEN;
               peer_nx  = '0;
               rcv_nx   = '0;
               snd_nx   = '0;
            end
         end else if (data_st) begin
            if (promote) state_nx = ESTABLISHED;
            if (in_order) begin
               rcv_nx = new_rcv;
               win_nx = m_win;
               if (f_fin) begin
                  snd_nx   = snd_nxt + 32'd1;
                  state_nx = LAST_ACK;
               end
            end
         end
      end
   end

   // payload verdict and outgoing request fields for the segment under evaluation
   always_comb begin
      commit_nx   = 1'b0;
      tx_load     = 1'b0;
      tx_flags_nx = '0;
      tx_seq_nx   = snd_nxt;
      tx_ack_nx   = rcv_nxt;
      if (eval && port_match && !rst_hit) begin
         if (state == LISTEN && f_syn && !f_ack) begin
            tx_load               = 1'b1;
            tx_flags_nx[FLAG_SYN] = 1'b1;
            tx_flags_nx[FLAG_ACK] = 1'b1;
            tx_seq_nx             = ISS;
            tx_ack_nx             = m_seq + 32'd1;
         end else if (data_st) begin
            commit_nx             = in_order && has_data;
            tx_load               = f_fin || has_data;
            tx_flags_nx[FLAG_ACK] = 1'b1;
            tx_flags_nx[FLAG_FIN] = in_order && f_fin;
            tx_ack_nx             = in_order ? new_rcv : rcv_nxt;
         end
      end
   end

   tcp_tx_req_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tx_load),
      .load_flags (tx_flags_nx),
      .load_seq   (tx_seq_nx),
      .load_ack   (tx_ack_nx),
      .load_dst   (peer_nx),
      .ready      (tx_req_ready),
      .valid      (tx_req_valid),
      .flags      (tx_req_flags),
      .seq        (tx_req_seq),
      .ack        (tx_req_ack),
      .dst_port   (tx_req_dst_port)
   );
endmodule
